// File: rtl/debug_sba_pkg.sv
// debug_sba_pkg: shared constants for the System Bus Access engine.
//   - DMI register addresses (sbcs, sbaddress0, sbdata0)
//   - FSM state enum, sberror / sbaccess codes, sbcs field positions
//   - misaligned(): alignment check of an address against an access size
package debug_sba_pkg;

  localparam logic [6:0] AddrSbcs       = 7'h38;
  localparam logic [6:0] AddrSbaddress0 = 7'h39;
  localparam logic [6:0] AddrSbdata0    = 7'h3C;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} sba_state_e;

  localparam logic [2:0] SbErrNone  = 3'd0;
  localparam logic [2:0] SbErrAlign = 3'd3;
  localparam logic [2:0] SbErrSize  = 3'd4;

  localparam logic [2:0] SbAccess8  = 3'd0;
  localparam logic [2:0] SbAccess16 = 3'd1;
  localparam logic [2:0] SbAccess32 = 3'd2;

  localparam int unsigned SbcsBusyErrBit    = 22;
  localparam int unsigned SbcsBusyBit       = 21;
  localparam int unsigned SbcsReadOnAddrBit = 20;
  localparam int unsigned SbcsAccessLsb     = 17;
  localparam int unsigned SbcsAutoIncBit    = 16;
  localparam int unsigned SbcsReadOnDataBit = 15;
  localparam int unsigned SbcsErrorLsb      = 12;

  function automatic logic misaligned(logic [2:0] access, logic [1:0] addr_lo);
    case (access)
      SbAccess16: misaligned = addr_lo[0];
      SbAccess32: misaligned = |addr_lo;
      default:    misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/debug_sba_if.sv
// debug_sba_if: DMI access port plus SYS_* request bus of the SBA engine.
//   slave  : view of the SBA engine (takes DMI accesses, drives SYS_* requests)
//   master : view of the environment (DMI host and the debug-to-CPU crossing)
interface debug_sba_if;
  logic        DMI_EN;
  logic        DMI_WR;
  logic [6:0]  DMI_AD;
  logic [31:0] DMI_DI;
  logic [31:0] DMI_DO;
  logic        SYS_EN;
  logic        SYS_WR;
  logic [3:0]  SYS_ST;
  logic [31:0] SYS_AD;
  logic [31:0] SYS_DI;
  logic [31:0] SYS_DO;

  modport slave (
    input  DMI_EN, DMI_WR, DMI_AD, DMI_DI, SYS_DO,
    output DMI_DO, SYS_EN, SYS_WR, SYS_ST, SYS_AD, SYS_DI
  );

  modport master (
    output DMI_EN, DMI_WR, DMI_AD, DMI_DI, SYS_DO,
    input  DMI_DO, SYS_EN, SYS_WR, SYS_ST, SYS_AD, SYS_DI
  );
endinterface

// File: rtl/debug_sba_lane.sv
// debug_sba_lane: combinational byte-lane steering.
//   size_i    : sbaccess code (0 byte, 1 half, 2 word)
//   addr_lo_i : byte offset within the 32-bit word
//   wdata_i   : write data (low-aligned)       -> wdata_o : lane-replicated write data
//   rdata_i   : raw read word from the crossing -> rdata_o : shifted, zero-extended data
//   strb_o    : byte strobes
module debug_sba_lane
  import debug_sba_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift;

  always_comb begin
    rshift  = rdata_i >> {addr_lo_i, 3'b000};
    strb_o  = 4'hF;
    wdata_o = wdata_i;
    rdata_o = rshift;
    case (size_i)
      SbAccess8: begin
        strb_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'b0, rshift[7:0]};
      end
      SbAccess16: begin
        strb_o  = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'b0, rshift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/debug_sba.sv
// debug_sba: RISC-V System Bus Access engine (debug-module clock domain).
// Decodes DMI accesses to sbcs / sbaddress0 / sbdata0 and issues timed
// requests on SYS_*: SYS_EN high for HOLD_CYCLES, low until WAIT_CYCLES after
// its rise, where SYS_DO is sampled (the crossing returns no completion).
//   CLK, RST_N : clock, synchronous active-low reset
//   sba_io     : debug_sba_if.slave (DMI_* access port, SYS_* request bus)
// Optional feature: define DEBUG_SBA_AUTOINC_EN to make sbautoincrement writable.
module debug_sba
  import debug_sba_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned WAIT_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  debug_sba_if.slave  sba_io
);

`ifdef DEBUG_SBA_AUTOINC_EN
  localparam logic AutoIncEn = 1'b1;
`else
  localparam logic AutoIncEn = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  sba_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        busyerr_q, busyerr_d;
  logic        readonaddr_q, readonaddr_d;
  logic [2:0]  sbaccess_q, sbaccess_d;
  logic        autoinc_q, autoinc_d;
  logic        readondata_q, readondata_d;
  logic [2:0]  sberror_q, sberror_d;
  logic [31:0] sbaddr_q, sbaddr_d;
  logic [31:0] sbdata_q, sbdata_d;
  logic [31:0] dmi_do_q, dmi_do_d;
  logic        sys_en_q, sys_en_d;
  logic        sys_wr_q, sys_wr_d;
  logic [3:0]  sys_st_q, sys_st_d;
  logic [31:0] sys_ad_q, sys_ad_d;
  logic [31:0] sys_di_q, sys_di_d;
  logic [2:0]  size_q, size_d;

  logic        busy, trig, trig_wr;
  logic [31:0] trig_addr, trig_wdata, sbcs_rdata;
  logic [2:0]  lane_size;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata, lane_rdata;

  assign busy = (state_q != StIdle);

  assign sbcs_rdata = {3'd1, 6'd0, busyerr_q, busy, readonaddr_q, sbaccess_q, autoinc_q,
                       readondata_q, sberror_q, 7'd32, 5'b00111};

  // Idle: steer the trigger's values; in flight: steer the latched access for read-back.
  assign lane_size = busy ? size_q : sbaccess_q;
  assign lane_addr = busy ? sys_ad_q[1:0] : trig_addr[1:0];

  debug_sba_lane u_lane (
    .size_i    (lane_size),
    .addr_lo_i (lane_addr),
    .wdata_i   (trig_wdata),
    .rdata_i   (sba_io.SYS_DO),
    .strb_o    (lane_strb),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busyerr_d    = busyerr_q;
    readonaddr_d = readonaddr_q;
    sbaccess_d   = sbaccess_q;
    autoinc_d    = autoinc_q;
    readondata_d = readondata_q;
    sberror_d    = sberror_q;
    sbaddr_d     = sbaddr_q;
    sbdata_d     = sbdata_q;
    dmi_do_d     = dmi_do_q;
    sys_en_d     = sys_en_q;
    sys_wr_d     = sys_wr_q;
    sys_st_d     = sys_st_q;
    sys_ad_d     = sys_ad_q;
    sys_di_d     = sys_di_q;
    size_d       = size_q;
    trig         = 1'b0;
    trig_wr      = 1'b0;
    trig_addr    = sbaddr_q;
    trig_wdata   = sbdata_q;

    // DMI decode
    if (sba_io.DMI_EN) begin
      if (!sba_io.DMI_WR) begin
        case (sba_io.DMI_AD)
          AddrSbcs:       dmi_do_d = sbcs_rdata;
          AddrSbaddress0: dmi_do_d = sbaddr_q;
          AddrSbdata0:    dmi_do_d = sbdata_q;
          default:        dmi_do_d = 32'd0;
        endcase
      end
      case (sba_io.DMI_AD)
        AddrSbcs: begin
          if (sba_io.DMI_WR) begin
            busyerr_d    = busyerr_q & ~sba_io.DMI_DI[SbcsBusyErrBit];
            readonaddr_d = sba_io.DMI_DI[SbcsReadOnAddrBit];
            sbaccess_d   = sba_io.DMI_DI[SbcsAccessLsb +: 3];
            autoinc_d    = AutoIncEn & sba_io.DMI_DI[SbcsAutoIncBit];
            readondata_d = sba_io.DMI_DI[SbcsReadOnDataBit];
            sberror_d    = sberror_q & ~sba_io.DMI_DI[SbcsErrorLsb +: 3];
          end
        end
        AddrSbaddress0: begin
          if (busy) begin
            busyerr_d = 1'b1;
          end else if (sba_io.DMI_WR) begin
            sbaddr_d  = sba_io.DMI_DI;
            trig_addr = sba_io.DMI_DI;
            trig      = readonaddr_q;
          end
        end
        AddrSbdata0: begin
          if (busy) begin
            busyerr_d = 1'b1;
          end else if (sba_io.DMI_WR) begin
            sbdata_d   = sba_io.DMI_DI;
            trig_wdata = sba_io.DMI_DI;
            trig       = 1'b1;
            trig_wr    = 1'b1;
          end else begin
            // Current value goes out on DMI_DO this edge; the refill starts now.
            trig = readondata_q;
          end
        end
        default: ;
      endcase
    end

    // Access FSM
    case (state_q)
      StIdle: begin
        if (trig && !busyerr_q && (sberror_q == SbErrNone)) begin
          if (sbaccess_q > SbAccess32) begin
            sberror_d = SbErrSize;
          end else if (misaligned(sbaccess_q, trig_addr[1:0])) begin
            sberror_d = SbErrAlign;
          end else begin
            state_d  = StReq;
            cnt_d    = '0;
            sys_en_d = 1'b1;
            sys_wr_d = trig_wr;
            sys_ad_d = trig_addr;
            sys_st_d = lane_strb;
            sys_di_d = lane_wdata;
            size_d   = sbaccess_q;
          end
        end
      end
      StReq: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          state_d  = StWait;
          cnt_d    = '0;
          sys_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        // WAIT plus the DONE cycle make up the SYS_EN-low phase, so SYS_DO is
        // sampled exactly WAIT_CYCLES after the SYS_EN rise.
        if (cnt_q == CntW'(WAIT_CYCLES - HOLD_CYCLES - 2)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (!sys_wr_q) begin
          sbdata_d = lane_rdata;
        end
        if (autoinc_q) begin
          sbaddr_d = sbaddr_q + (32'd1 << size_q);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      busyerr_q    <= 1'b0;
      readonaddr_q <= 1'b0;
      sbaccess_q   <= SbAccess32;
      autoinc_q    <= 1'b0;
      readondata_q <= 1'b0;
      sberror_q    <= SbErrNone;
      sbaddr_q     <= '0;
      sbdata_q     <= '0;
      dmi_do_q     <= '0;
      sys_en_q     <= 1'b0;
      sys_wr_q     <= 1'b0;
      sys_st_q     <= '0;
      sys_ad_q     <= '0;
      sys_di_q     <= '0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busyerr_q    <= busyerr_d;
      readonaddr_q <= readonaddr_d;
      sbaccess_q   <= sbaccess_d;
      autoinc_q    <= autoinc_d;
      readondata_q <= readondata_d;
      sberror_q    <= sberror_d;
      sbaddr_q     <= sbaddr_d;
      sbdata_q     <= sbdata_d;
      dmi_do_q     <= dmi_do_d;
      sys_en_q     <= sys_en_d;
      sys_wr_q     <= sys_wr_d;
      sys_st_q     <= sys_st_d;
      sys_ad_q     <= sys_ad_d;
      sys_di_q     <= sys_di_d;
      size_q       <= size_d;
    end
  end

  assign sba_io.DMI_DO = dmi_do_q;
  assign sba_io.SYS_EN = sys_en_q;
  assign sba_io.SYS_WR = sys_wr_q;
  assign sba_io.SYS_ST = sys_st_q;
  assign sba_io.SYS_AD = sys_ad_q;
  assign sba_io.SYS_DI = sys_di_q;

endmodule

// File: tb/tb_debug_sba.sv
// tb_debug_sba: directed self-checking bench for debug_sba.
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_debug_sba;
  import debug_sba_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_hi   = 0;

  debug_sba_if bus ();

  debug_sba u_dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .sba_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count falling edges with SYS_EN high.
  always @(negedge clk) if (bus.SYS_EN) en_hi++;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the access is sampled by the next rising edge.
  task automatic dmi_write(input logic [6:0] ad, input logic [31:0] d);
    bus.DMI_EN = 1'b1; bus.DMI_WR = 1'b1; bus.DMI_AD = ad; bus.DMI_DI = d;
    @(negedge clk);
    bus.DMI_EN = 1'b0; bus.DMI_WR = 1'b0;
  endtask

  task automatic dmi_read(input logic [6:0] ad, output logic [31:0] d);
    bus.DMI_EN = 1'b1; bus.DMI_WR = 1'b0; bus.DMI_AD = ad;
    @(negedge clk);
    bus.DMI_EN = 1'b0;
    d = bus.DMI_DO;
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      dmi_read(AddrSbcs, v);
      if (!v[21]) done = 1'b1;
    end
    check_eq("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  logic [31:0] rd;
  int          base;
  logic [31:0] exp_ad;

  initial begin
    rst_n = 1'b0;
    bus.DMI_EN = 1'b0; bus.DMI_WR = 1'b0; bus.DMI_AD = '0; bus.DMI_DI = '0;
    bus.SYS_DO = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_sys_en", {31'd0, bus.SYS_EN}, 32'd0);
    check_eq("rst_sys_ad", bus.SYS_AD, 32'd0);
    check_eq("rst_sys_st", {28'd0, bus.SYS_ST}, 32'd0);
    check_eq("rst_dmi_do", bus.DMI_DO, 32'd0);
    dmi_read(AddrSbcs, rd);       check_eq("rst_sbcs", rd, 32'h2004_0407);
    dmi_read(AddrSbaddress0, rd); check_eq("rst_sbaddr", rd, 32'd0);
    dmi_read(AddrSbdata0, rd);    check_eq("rst_sbdata", rd, 32'd0);
    dmi_read(7'h10, rd);          check_eq("unmapped_rd", rd, 32'd0);

    // Word write: SYS_EN rises at E0
    dmi_write(AddrSbcs, 32'h0004_0000);
    dmi_write(AddrSbaddress0, 32'h0000_1000);
    base = en_hi;
    dmi_write(AddrSbdata0, 32'hDEAD_BEEF);
    check_eq("ww_en", {31'd0, bus.SYS_EN}, 32'd1);
    check_eq("ww_wr", {31'd0, bus.SYS_WR}, 32'd1);
    check_eq("ww_ad", bus.SYS_AD, 32'h0000_1000);
    check_eq("ww_st", {28'd0, bus.SYS_ST}, 32'h0000_000F);
    check_eq("ww_di", bus.SYS_DI, 32'hDEAD_BEEF);
    repeat (30) @(negedge clk);
    dmi_read(AddrSbcs, rd);       check_eq("ww_busy_e31", {31'd0, rd[21]}, 32'd1);
    @(negedge clk);
    dmi_read(AddrSbcs, rd);       check_eq("ww_busy_e33", {31'd0, rd[21]}, 32'd0);
    check_eq("ww_en_cycles", 32'(en_hi - base), 32'd8);

    // Byte read at offset 3 with sbreadonaddr
    bus.SYS_DO = 32'hAB00_0000;
    dmi_write(AddrSbcs, 32'h0010_0000);
    dmi_write(AddrSbaddress0, 32'h0000_2003);
    check_eq("br_en", {31'd0, bus.SYS_EN}, 32'd1);
    check_eq("br_wr", {31'd0, bus.SYS_WR}, 32'd0);
    check_eq("br_st", {28'd0, bus.SYS_ST}, 32'h0000_0008);
    wait_idle();
    dmi_read(AddrSbdata0, rd);    check_eq("br_data", rd, 32'h0000_00AB);

    // Misaligned word address, then oversize access
    dmi_write(AddrSbcs, 32'h0014_0000);
    dmi_write(AddrSbaddress0, 32'h0000_1002);
    check_eq("al_no_en", {31'd0, bus.SYS_EN}, 32'd0);
    dmi_read(AddrSbcs, rd);       check_eq("al_sbcs", rd, 32'h2014_3407);
    dmi_write(AddrSbcs, 32'h0000_7000);
    dmi_read(AddrSbcs, rd);       check_eq("al_clear", rd, 32'h2000_0407);
    dmi_write(AddrSbcs, 32'h0006_0000);
    dmi_write(AddrSbdata0, 32'h1234_5678);
    check_eq("sz_no_en", {31'd0, bus.SYS_EN}, 32'd0);
    dmi_read(AddrSbcs, rd);       check_eq("sz_sbcs", rd, 32'h2006_4407);
    dmi_write(AddrSbcs, 32'h0004_7000);
    dmi_read(AddrSbcs, rd);       check_eq("sz_clear", rd, 32'h2004_0407);

    // Busy access: second sbdata0 write sampled 5 cycles into the access
    dmi_write(AddrSbaddress0, 32'h0000_1000);
    dmi_write(AddrSbdata0, 32'h1122_3344);
    repeat (4) @(negedge clk);
    dmi_write(AddrSbdata0, 32'h5566_7788);
    check_eq("bz_di_stable", bus.SYS_DI, 32'h1122_3344);
    wait_idle();
    dmi_read(AddrSbcs, rd);       check_eq("bz_sbcs", rd, 32'h2044_0407);
    dmi_write(AddrSbdata0, 32'h9999_9999);
    check_eq("bz_blocked", {31'd0, bus.SYS_EN}, 32'd0);
    dmi_write(AddrSbcs, 32'h0044_0000);
    dmi_read(AddrSbcs, rd);       check_eq("bz_clear", rd, 32'h2004_0407);
    dmi_write(AddrSbdata0, 32'hA5A5_A5A5);
    check_eq("bz_restart_en", {31'd0, bus.SYS_EN}, 32'd1);
    check_eq("bz_restart_di", bus.SYS_DI, 32'hA5A5_A5A5);
    wait_idle();

    // sbreadondata chain, with auto-increment when built in
    dmi_write(AddrSbaddress0, 32'h0000_3000);
    dmi_write(AddrSbcs, 32'h0005_8000);
    dmi_read(AddrSbcs, rd);
`ifdef DEBUG_SBA_AUTOINC_EN
    check_eq("rd_sbcs", rd, 32'h2005_8407);
`else
    check_eq("rd_sbcs", rd, 32'h2004_8407);
`endif
    for (int i = 0; i < 3; i++) begin
      bus.SYS_DO = 32'h1000_0000 + 32'(i);
      dmi_read(AddrSbdata0, rd);
      check_eq("rd_value", rd, (i == 0) ? 32'hA5A5_A5A5 : 32'h1000_0000 + 32'(i - 1));
`ifdef DEBUG_SBA_AUTOINC_EN
      exp_ad = 32'h0000_3000 + 32'(4 * i);
`else
      exp_ad = 32'h0000_3000;
`endif
      check_eq("rd_en", {31'd0, bus.SYS_EN}, 32'd1);
      check_eq("rd_ad", bus.SYS_AD, exp_ad);
      wait_idle();
    end
    dmi_read(AddrSbaddress0, rd);
`ifdef DEBUG_SBA_AUTOINC_EN
    check_eq("rd_final_addr", rd, 32'h0000_300C);
`else
    check_eq("rd_final_addr", rd, 32'h0000_3000);
`endif
    dmi_write(AddrSbcs, 32'h0004_0000);
    dmi_read(AddrSbdata0, rd);    check_eq("rd_last", rd, 32'h1000_0002);

    // Reset during REQ
    dmi_write(AddrSbdata0, 32'h0000_0001);
    check_eq("rs_en_before", {31'd0, bus.SYS_EN}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rs_en_after", {31'd0, bus.SYS_EN}, 32'd0);
    check_eq("rs_di_after", bus.SYS_DI, 32'd0);
    rst_n = 1'b1;
    dmi_read(AddrSbcs, rd);       check_eq("rs_sbcs", rd, 32'h2004_0407);
    dmi_read(AddrSbaddress0, rd); check_eq("rs_sbaddr", rd, 32'd0);
    dmi_write(AddrSbdata0, 32'h0000_0077);
    check_eq("rs_idle_start", {31'd0, bus.SYS_EN}, 32'd1);
    check_eq("rs_idle_di", bus.SYS_DI, 32'h0000_0077);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
